// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared codes for the FPU issue controller: instruction/rounding codes, FSM states, flag bit indices.
// Operand and response bundles are packed so they register as single words.
package fpu_issue_ctrl_pkg;

  localparam logic [3:0] FPU_INSTR_FP2SI       = 4'd6;
  localparam logic [1:0] ROUNDING_MODE_NEAREST = 2'd0;
  localparam logic [1:0] ROUNDING_MODE_TRUNC   = 2'd1;

  localparam int FLAG_INEXACT      = 0;
  localparam int FLAG_UNDERFLOW    = 1;
  localparam int FLAG_OVERFLOW     = 2;
  localparam int FLAG_DIV_BY_ZERO  = 3;
  localparam int FLAG_INVALID      = 4;

  typedef enum logic [1:0] {
    FIC_ST_IDLE   = 2'd0,
    FIC_ST_LAUNCH = 2'd1,
    FIC_ST_RUN    = 2'd2,
    FIC_ST_RESP   = 2'd3
  } ficState_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [1:0]  rmode;
    logic [31:0] a;
    logic [31:0] b;
  } fpuOp_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        timeout;
  } fpuRsp_t;

endpackage

// File: rtl/fpu_issue_ctrl_edge_det.sv
// Registered 0->1 detector; latency 0 (rise is combinational from the input and last-cycle register).
// No backpressure; the register resets high so a level already high out of reset is not an edge.
module fpu_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic inQ;

  always_ff @(posedge clk) begin
    if (reset) inQ <= 1'b1;
    else       inQ <= in;
  end

  assign rise = in & ~inQ;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue stage for FPU_top: holds operands stable through RST_HOLD reset cycles, runs until a resultReady
// rising edge or TIMEOUT, then returns the result; req_ready only in IDLE, response held until rsp_ready.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 2,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [1:0]  req_rmode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        fpu_reset,
  output logic [3:0]  fpu_opcode,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_result_ready,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  ficState_t       state, nextState;
  logic [HW-1:0]   holdCnt;
  logic [TO_W-1:0] toCnt;
  logic [TO_W-1:0] toNext;
  logic            toHit;
  logic            fpuRise;
  fpuOp_t          opQ;
  fpuRsp_t         rspQ;

  // Edge register runs in every state so a level left high from before RUN never counts as new.
  fpu_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (fpu_result_ready),
    .rise  (fpuRise)
  );

  assign toNext = toCnt + 1'b1;
  assign toHit  = (toNext == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state <= FIC_ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    fpu_reset = 1'b1;
    case (state)
      FIC_ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nextState = FIC_ST_LAUNCH;
      end
      FIC_ST_LAUNCH: begin
        if (holdCnt == '0) nextState = FIC_ST_RUN;
      end
      FIC_ST_RUN: begin
        fpu_reset = 1'b0;
        if (fpuRise || toHit) nextState = FIC_ST_RESP;
      end
      FIC_ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nextState = FIC_ST_IDLE;
      end
      default: nextState = FIC_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdCnt <= '0;
      toCnt   <= '0;
      opQ     <= '0;
      rspQ    <= '0;
    end else begin
      case (state)
        FIC_ST_IDLE: begin
          if (req_valid) begin
            opQ     <= '{opcode: req_opcode, rmode: req_rmode, a: req_a, b: req_b};
            holdCnt <= HW'(RST_HOLD - 1);
            toCnt   <= '0;
          end
        end
        FIC_ST_LAUNCH: begin
          if (holdCnt != '0) holdCnt <= holdCnt - 1'b1;
        end
        FIC_ST_RUN: begin
          if (fpuRise)    rspQ <= '{result: fpu_result, flags: fpu_flags, timeout: 1'b0};
          else if (toHit) rspQ <= '{result: 32'h0, flags: 5'h00, timeout: 1'b1};
          else            toCnt <= toNext;
        end
        default: ;
      endcase
    end
  end

  assign fpu_opcode  = opQ.opcode;
  assign fpu_rmode   = opQ.rmode;
  assign fpu_a       = opQ.a;
  assign fpu_b       = opQ.b;
  assign rsp_result  = rspQ.result;
  assign rsp_flags   = rspQ.flags;
  assign rsp_timeout = rspQ.timeout;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural FP2SI stand-in for FPU_top,
// a never-ready stub mode and a manually driven resultReady mode.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_opcode;
  logic [1:0]  req_rmode;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout;
  logic        fpu_reset;
  logic [3:0]  fpu_opcode;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_result_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.RST_HOLD(2), .TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_rmode(req_rmode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .fpu_reset(fpu_reset), .fpu_opcode(fpu_opcode), .fpu_rmode(fpu_rmode),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result_ready(fpu_result_ready),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags)
  );

  int nVec = 0;
  int nBad = 0;

  // Stub FPU: 0 = FP2SI after stubLat cycles, 1 = never ready, 2 = manual.
  int          stubMode = 0;
  int          stubLat  = 1;
  int          stubCnt  = 0;
  logic        stubRdy  = 1'b0;
  logic [31:0] stubRes  = 32'hDEADBEEF;
  logic [4:0]  stubFlags = 5'h1F;
  logic        manRdy   = 1'b0;
  logic [31:0] manRes   = 32'h0;
  logic [4:0]  manFlags = 5'h0;

  assign fpu_result_ready = (stubMode == 2) ? manRdy   : (stubMode == 1) ? 1'b0         : stubRdy;
  assign fpu_result       = (stubMode == 2) ? manRes   : (stubMode == 1) ? 32'hDEADBEEF : stubRes;
  assign fpu_flags        = (stubMode == 2) ? manFlags : (stubMode == 1) ? 5'h1F        : stubFlags;

  function automatic void fp2si(input logic [31:0] a, output logic [31:0] r, output logic [4:0] f);
    int e, sh;
    logic [31:0] m, mag;
    e = int'(a[30:23]);
    m = {8'h00, 1'b1, a[22:0]};
    f = '0;
    mag = '0;
    if (e >= 158) begin
      f[FLAG_INVALID] = 1'b1;
      r = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (e < 127) begin
      r = '0;
      f[FLAG_INEXACT] = (a[30:0] != 31'h0);
    end else begin
      if (e >= 150) mag = m << (e - 150);
      else begin
        sh = 150 - e;
        mag = m >> sh;
        f[FLAG_INEXACT] = ((m << (32 - sh)) != 32'h0);
      end
      r = a[31] ? -mag : mag;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (fpu_reset !== 1'b0) begin
        stubRdy = 1'b0; stubCnt = 0; stubRes = 32'hDEADBEEF; stubFlags = 5'h1F;
      end else begin
        stubCnt++;
        if (stubCnt >= stubLat) begin
          fp2si(fpu_a, stubRes, stubFlags);
          stubRdy = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveReq(input logic [3:0] op, input logic [1:0] rm, input logic [31:0] a, input logic [31:0] b);
    req_opcode = op; req_rmode = rm; req_a = a; req_b = b; req_valid = 1'b1;
  endtask

  task automatic waitAccept(output int waited);
    waited = 0;
    while (!req_ready && waited < 100) begin waited++; @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int hold, output int run);
    int n;
    hold = 0; run = 0; n = 0;
    while (fpu_reset && n < 50) begin hold++; n++; @(negedge clk); end
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (!fpu_reset) run++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_drain_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({name, "_drain_req_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  typedef struct {
    string       name;
    int          mode;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic [4:0]  expFlags;
    logic        expTo;
    int          expRun;
    int          stall;
  } vec_t;

  vec_t vecs[7];

  task automatic doVec(input vec_t v);
    int waited, hold, run, stallBad;
    stubMode = v.mode;
    stubLat  = v.lat;
    @(negedge clk);
    driveReq(FPU_INSTR_FP2SI, ROUNDING_MODE_TRUNC, v.a, v.b);
    waitAccept(waited);
    waitRsp(hold, run);
    chk({v.name, "_hold"},    hold,                    32'd2);
    chk({v.name, "_run"},     run,                     v.expRun);
    chk({v.name, "_result"},  rsp_result,              v.expRes);
    chk({v.name, "_flags"},   {27'h0, rsp_flags},      {27'h0, v.expFlags});
    chk({v.name, "_timeout"}, {31'h0, rsp_timeout},    {31'h0, v.expTo});
    chk({v.name, "_fpu_ab"},  fpu_a ^ fpu_b,           v.a ^ v.b);
    if (v.stall > 0) begin
      stallBad = 0;
      for (int i = 0; i < v.stall; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_result !== v.expRes || rsp_flags !== v.expFlags ||
            req_ready !== 1'b0 || fpu_reset !== 1'b1) stallBad++;
      end
      chk({v.name, "_stall_unstable_cycles"}, stallBad, 32'd0);
    end
    drain(v.name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, hold, run, sawValid;

    vecs[0] = '{"pi_trunc", 0, 3, 32'h40490FDB, 32'h3F800000, 32'h00000003, 5'b00001, 1'b0, 3,  0};
    vecs[1] = '{"neg123",   0, 1, 32'hC2F60000, 32'h00000000, 32'hFFFFFF85, 5'b00000, 1'b0, 1,  0};
    vecs[2] = '{"stall",    0, 2, 32'h3F000000, 32'h12345678, 32'h00000000, 5'b00001, 1'b0, 2,  10};
    vecs[3] = '{"timeout",  1, 1, 32'h40000000, 32'hCAFEF00D, 32'h00000000, 5'b00000, 1'b1, 16, 0};
    vecs[4] = '{"two",      0, 5, 32'h40000000, 32'h00000001, 32'h00000002, 5'b00000, 1'b0, 5,  0};
    vecs[5] = '{"neg1p5",   0, 4, 32'hBFC00000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, 4,  0};
    vecs[6] = '{"big",      0, 2, 32'h501502F9, 32'h00000000, 32'h7FFFFFFF, 5'b10000, 1'b0, 2,  0};

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_rmode = ROUNDING_MODE_NEAREST; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",   {31'h0, req_ready},   32'h1);
    chk("rst_fpu_reset",   {31'h0, fpu_reset},   32'h1);
    chk("rst_rsp_valid",   {31'h0, rsp_valid},   32'h0);
    chk("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    chk("rst_rsp_result",  rsp_result,           32'h0);
    chk("rst_rsp_flags",   {27'h0, rsp_flags},   32'h0);
    chk("rst_fpu_op_rm",   {26'h0, fpu_opcode, fpu_rmode}, 32'h0);
    chk("rst_fpu_a",       fpu_a,                32'h0);
    chk("rst_fpu_b",       fpu_b,                32'h0);
    reset = 1'b0;

    foreach (vecs[i]) doVec(vecs[i]);

    // Back-to-back: second request waits on the drain edge and is taken on the following edge.
    stubMode = 0; stubLat = 2;
    @(negedge clk);
    driveReq(FPU_INSTR_FP2SI, ROUNDING_MODE_TRUNC, 32'hC2F60000, 32'h0);
    waitAccept(waited);
    waitRsp(hold, run);
    chk("b2b_first_result", rsp_result, 32'hFFFFFF85);
    driveReq(FPU_INSTR_FP2SI, ROUNDING_MODE_TRUNC, 32'h40490FDB, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_drain_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("b2b_drain_req_ready", {31'h0, req_ready}, 32'h1);
    waitAccept(waited);
    chk("b2b_accept_wait", waited, 32'd0);
    chk("b2b_second_fpu_a", fpu_a, 32'h40490FDB);
    waitRsp(hold, run);
    chk("b2b_second_result", rsp_result, 32'h00000003);
    chk("b2b_second_flags", {27'h0, rsp_flags}, 32'h1);
    drain("b2b_second");

    // Reset pulse mid-RUN with a hung FPU.
    stubMode = 1;
    @(negedge clk);
    driveReq(FPU_INSTR_FP2SI, ROUNDING_MODE_TRUNC, 32'h40000000, 32'h0);
    waitAccept(waited);
    waitRsp(hold, run);
    for (int i = 0; i < 100 && fpu_reset; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_fpu_reset", {31'h0, fpu_reset}, 32'h1);
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midrst_fpu_a",     fpu_a,              32'h0);
    sawValid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) sawValid++;
    end
    chk("midrst_spurious_rsp", sawValid, 32'd0);
    doVec('{"after_rst", 0, 2, 32'hBFC00000, 32'h0, 32'hFFFFFFFF, 5'b00001, 1'b0, 2, 0});

    // resultReady already high before RUN must not be captured until a fresh 0->1.
    stubMode = 2; manRdy = 1'b1; manRes = 32'h11111111; manFlags = 5'h1F;
    @(negedge clk);
    driveReq(FPU_INSTR_FP2SI, ROUNDING_MODE_TRUNC, 32'h40000000, 32'h0);
    waitAccept(waited);
    for (int i = 0; i < 100 && fpu_reset; i++) @(negedge clk);
    chk("stale_in_run", {31'h0, fpu_reset}, 32'h0);
    sawValid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) sawValid++;
    end
    manRdy = 1'b0;
    @(negedge clk);
    if (rsp_valid !== 1'b0) sawValid++;
    chk("stale_no_capture", sawValid, 32'd0);
    manRes = 32'h00000007; manFlags = 5'b00001; manRdy = 1'b1;
    @(negedge clk);
    chk("stale_rsp_valid", {31'h0, rsp_valid},   32'h1);
    chk("stale_result",    rsp_result,           32'h00000007);
    chk("stale_flags",     {27'h0, rsp_flags},   32'h1);
    chk("stale_timeout",   {31'h0, rsp_timeout}, 32'h0);
    drain("stale");
    manRdy = 1'b0;
    stubMode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
